// File: rtl/trace_capture.sv
// Response recorder: captures sample_data while armed, then replays the samples over valid/ready.
// Optional change-compressed capture is enabled with `define TRACE_DELTA_EN.
module trace_capture #(
  parameter int WIDTH  = 3,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              arm,
  input  logic              stop,
  input  logic              sample_en,
  input  logic [WIDTH-1:0]  sample_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [WIDTH-1:0]  rd_data,
  output logic              rd_last,
  output logic [ADDR_W:0]   count,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CAPTURE,
    S_DUMP
  } state_e;

  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0] ONE_CNT  = (ADDR_W + 1)'(1);

  state_e              state_q;
  logic [WIDTH-1:0]    mem [DEPTH];
  logic [ADDR_W-1:0]   wr_ptr_q;
  logic [ADDR_W-1:0]   rd_ptr_q;
  logic [ADDR_W:0]     count_q;
  logic [ADDR_W:0]     count_d;
  logic                done_q;
  logic                wr_en;

`ifdef TRACE_DELTA_EN
  // Only the first sample and value changes are kept, like a VCD dump.
  logic [WIDTH-1:0] last_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q <= '0;
    end else if (wr_en) begin
      last_q <= sample_data;
    end
  end

  assign wr_en = (state_q == S_CAPTURE) && sample_en &&
                 ((count_q == '0) || (sample_data != last_q));
`else
  assign wr_en = (state_q == S_CAPTURE) && sample_en;
`endif

  assign count_d = count_q + (ADDR_W + 1)'(wr_en);

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr_q] <= sample_data;
    end
  end

  // Read side: a beat transfers when rd_valid && rd_ready; rd_data/rd_last
  // are decoded from rd_ptr_q, so they hold while rd_ready is low.
  assign rd_valid = (state_q == S_DUMP);
  assign rd_last  = rd_valid && ({1'b0, rd_ptr_q} == (count_q - ONE_CNT));
  assign rd_data  = rd_valid ? mem[rd_ptr_q] : '0;
  assign busy     = (state_q != S_IDLE);
  assign count    = count_q;
  assign done     = done_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (arm) begin
            state_q  <= S_CAPTURE;
            wr_ptr_q <= '0;
            count_q  <= '0;
          end
        end
        S_CAPTURE: begin
          if (wr_en) begin
            wr_ptr_q <= wr_ptr_q + 1'b1;
            count_q  <= count_d;
          end
          if (count_d == FULL_CNT) begin
            state_q  <= S_DUMP;
            rd_ptr_q <= '0;
          end else if (stop) begin
            if (count_d != '0) begin
              state_q  <= S_DUMP;
              rd_ptr_q <= '0;
            end else begin
              state_q <= S_IDLE;
              done_q  <= 1'b1;
            end
          end
        end
        S_DUMP: begin
          if (rd_ready) begin
            if (rd_last) begin
              state_q <= S_IDLE;
              done_q  <= 1'b1;
            end else begin
              rd_ptr_q <= rd_ptr_q + 1'b1;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_trace_capture.sv
// Directed bench for trace_capture: capture, full, backpressure, empty stop, mid-dump reset, delta mode.
module tb_trace_capture;

  localparam int WIDTH  = 3;
  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;

  logic              clk;
  logic              rst;
  logic              arm;
  logic              stop;
  logic              sample_en;
  logic [WIDTH-1:0]  sample_data;
  logic              rd_valid;
  logic              rd_ready;
  logic [WIDTH-1:0]  rd_data;
  logic              rd_last;
  logic [ADDR_W:0]   count;
  logic              busy;
  logic              done;

  int errors = 0;
  int checks = 0;
  logic [WIDTH-1:0] exp_q[$];

  trace_capture #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .arm(arm), .stop(stop),
    .sample_en(sample_en), .sample_data(sample_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
    .rd_last(rd_last), .count(count), .busy(busy), .done(done)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_arm();
    arm = 1'b1;
    step();
    arm = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; arm = 1'b0; stop = 1'b0; sample_en = 1'b0;
    sample_data = '0; rd_ready = 1'b0;
    step(); step();
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL reset_rd_valid got=%b exp=0", rd_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (count !== 5'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", count); end
    checks++; if (rd_data !== 3'd0) begin errors++; $display("FAIL reset_rd_data got=%0d exp=0", rd_data); end
    checks++; if (rd_last !== 1'b0) begin errors++; $display("FAIL reset_rd_last got=%b exp=0", rd_last); end
    rst = 1'b0;
    step();
  endtask

  task automatic test_basic();
    logic [WIDTH-1:0] vals[4] = '{3'd0, 3'd3, 3'd5, 3'd6};
    do_arm();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy_capture got=%b exp=1", busy); end
    for (int i = 0; i < 4; i++) begin
      sample_en = 1'b1; sample_data = vals[i]; stop = (i == 3);
      exp_q.push_back(vals[i]);
      step();
    end
    sample_en = 1'b0; stop = 1'b0;
    checks++; if (count !== 5'd4) begin errors++; $display("FAIL basic_count got=%0d exp=4", count); end
    checks++; if (rd_valid !== 1'b1) begin errors++; $display("FAIL basic_rd_valid_rise got=%b exp=1", rd_valid); end
    rd_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++; if (rd_data !== exp_q[0]) begin errors++; $display("FAIL basic_rd_data beat=%0d got=%0d exp=%0d", i, rd_data, exp_q[0]); end
      checks++; if (rd_last !== (i == 3)) begin errors++; $display("FAIL basic_rd_last beat=%0d got=%b exp=%b", i, rd_last, (i == 3)); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL basic_done_early beat=%0d got=%b exp=0", i, done); end
      void'(exp_q.pop_front());
      step();
    end
    rd_ready = 1'b0;
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL basic_done_pulse got=%b exp=1", done); end
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL basic_rd_valid_drop got=%b exp=0", rd_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_fall got=%b exp=0", busy); end
    step();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL basic_done_width got=%b exp=0", done); end
    checks++; if (count !== 5'd4) begin errors++; $display("FAIL basic_count_hold got=%0d exp=4", count); end
  endtask

  task automatic test_full();
    do_arm();
    for (int i = 0; i < 20; i++) begin
      sample_en = 1'b1; sample_data = i[2:0];
      if (i < DEPTH) exp_q.push_back(i[2:0]);
      step();
    end
    sample_en = 1'b0;
    checks++; if (count !== 5'd16) begin errors++; $display("FAIL full_count got=%0d exp=16", count); end
    checks++; if (rd_valid !== 1'b1) begin errors++; $display("FAIL full_rd_valid got=%b exp=1", rd_valid); end
    rd_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      checks++; if (rd_data !== exp_q[0]) begin errors++; $display("FAIL full_rd_data beat=%0d got=%0d exp=%0d", i, rd_data, exp_q[0]); end
      checks++; if (rd_last !== (i == DEPTH - 1)) begin errors++; $display("FAIL full_rd_last beat=%0d got=%b exp=%b", i, rd_last, (i == DEPTH - 1)); end
      void'(exp_q.pop_front());
      step();
    end
    rd_ready = 1'b0;
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL full_done got=%b exp=1", done); end
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL full_rd_valid_drop got=%b exp=0", rd_valid); end
    step();
  endtask

  task automatic test_backpressure();
    logic [WIDTH-1:0] vals[5] = '{3'd7, 3'd1, 3'd2, 3'd4, 3'd6};
    int cyc;
    do_arm();
    for (int i = 0; i < 5; i++) begin
      sample_en = 1'b1; sample_data = vals[i]; stop = (i == 4);
      exp_q.push_back(vals[i]);
      step();
    end
    sample_en = 1'b0; stop = 1'b0;
    checks++; if (count !== 5'd5) begin errors++; $display("FAIL bp_count got=%0d exp=5", count); end
    cyc = 0;
    while (exp_q.size() > 0 && cyc < 60) begin
      rd_ready = ((cyc % 3) == 0);
      checks++; if (rd_valid !== 1'b1) begin errors++; $display("FAIL bp_rd_valid cyc=%0d got=%b exp=1", cyc, rd_valid); end
      checks++; if (rd_data !== exp_q[0]) begin errors++; $display("FAIL bp_rd_data cyc=%0d got=%0d exp=%0d", cyc, rd_data, exp_q[0]); end
      checks++; if (rd_last !== (exp_q.size() == 1)) begin errors++; $display("FAIL bp_rd_last cyc=%0d got=%b exp=%b", cyc, rd_last, (exp_q.size() == 1)); end
      if (rd_ready) void'(exp_q.pop_front());
      step();
      cyc++;
    end
    rd_ready = 1'b0;
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL bp_timeout left=%0d exp=0", exp_q.size()); exp_q.delete(); end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL bp_done got=%b exp=1", done); end
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL bp_rd_valid_drop got=%b exp=0", rd_valid); end
    step();
  endtask

  task automatic test_empty_stop();
    do_arm();
    stop = 1'b1;
    step();
    stop = 1'b0;
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL empty_done got=%b exp=1", done); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL empty_busy got=%b exp=0", busy); end
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL empty_rd_valid got=%b exp=0", rd_valid); end
    checks++; if (count !== 5'd0) begin errors++; $display("FAIL empty_count got=%0d exp=0", count); end
    step();
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL empty_rd_valid_after got=%b exp=0", rd_valid); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL empty_done_width got=%b exp=0", done); end
  endtask

  task automatic test_reset_mid_dump();
    logic [WIDTH-1:0] vals[2] = '{3'd5, 3'd2};
    do_arm();
    for (int i = 0; i < 4; i++) begin
      sample_en = 1'b1; sample_data = 3'(i + 1); stop = (i == 3);
      step();
    end
    sample_en = 1'b0; stop = 1'b0;
    rd_ready = 1'b1;
    step(); step();
    rd_ready = 1'b0;
    checks++; if (rd_data !== 3'd3) begin errors++; $display("FAIL rstmid_pre_data got=%0d exp=3", rd_data); end
    rst = 1'b1;
    #1;
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL rstmid_rd_valid got=%b exp=0", rd_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got=%b exp=0", busy); end
    checks++; if (count !== 5'd0) begin errors++; $display("FAIL rstmid_count got=%0d exp=0", count); end
    step();
    rst = 1'b0;
    step();
    do_arm();
    for (int i = 0; i < 2; i++) begin
      sample_en = 1'b1; sample_data = vals[i]; stop = (i == 1);
      exp_q.push_back(vals[i]);
      step();
    end
    sample_en = 1'b0; stop = 1'b0;
    checks++; if (count !== 5'd2) begin errors++; $display("FAIL rstmid_new_count got=%0d exp=2", count); end
    rd_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      checks++; if (rd_data !== exp_q[0]) begin errors++; $display("FAIL rstmid_rd_data beat=%0d got=%0d exp=%0d", i, rd_data, exp_q[0]); end
      checks++; if (rd_last !== (i == 1)) begin errors++; $display("FAIL rstmid_rd_last beat=%0d got=%b exp=%b", i, rd_last, (i == 1)); end
      void'(exp_q.pop_front());
      step();
    end
    rd_ready = 1'b0;
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL rstmid_done got=%b exp=1", done); end
    step();
  endtask

  task automatic test_delta();
    logic [WIDTH-1:0] vals[6] = '{3'd1, 3'd1, 3'd1, 3'd2, 3'd2, 3'd4};
    int n;
    do_arm();
    for (int i = 0; i < 6; i++) begin
      sample_en = 1'b1; sample_data = vals[i]; stop = (i == 5);
`ifdef TRACE_DELTA_EN
      if (i == 0 || vals[i] != vals[i-1]) exp_q.push_back(vals[i]);
`else
      exp_q.push_back(vals[i]);
`endif
      step();
    end
    sample_en = 1'b0; stop = 1'b0;
`ifdef TRACE_DELTA_EN
    n = 3;
`else
    n = 6;
`endif
    checks++; if (count !== 5'(n)) begin errors++; $display("FAIL delta_count got=%0d exp=%0d", count, n); end
    rd_ready = 1'b1;
    for (int i = 0; i < n; i++) begin
      checks++; if (rd_data !== exp_q[0]) begin errors++; $display("FAIL delta_rd_data beat=%0d got=%0d exp=%0d", i, rd_data, exp_q[0]); end
      checks++; if (rd_last !== (i == n - 1)) begin errors++; $display("FAIL delta_rd_last beat=%0d got=%b exp=%b", i, rd_last, (i == n - 1)); end
      void'(exp_q.pop_front());
      step();
    end
    rd_ready = 1'b0;
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL delta_done got=%b exp=1", done); end
    step();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_full();
    test_backpressure();
    test_empty_stop();
    test_reset_mid_dump();
    test_delta();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/trace_capture.md
Name: trace_capture

Overview:
- Synthesizable response recorder: the capture side of our stimulus/response flow.
- Records a DUT output vector into an internal buffer while armed, then streams the recorded samples out over a valid/ready interface for comparison or logging.
- Sits beside the DUT. Its input is the same signal set our benches dump to VCD, and its output feeds a checker or host reader.

Parameters:
- WIDTH, 3, bits per captured sample.
- DEPTH, 16, buffer entries; power of two, at least 2.
- ADDR_W, 4, log2(DEPTH).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- arm  input  1  single-cycle pulse; starts a capture from IDLE
- stop  input  1  ends capture early; honoured only in CAPTURE
- sample_en  input  1  sample_data is valid this cycle
- sample_data  input  WIDTH  DUT vector to record
- rd_valid  output  1  rd_data holds a recorded sample
- rd_ready  input  1  consumer accepts rd_data
- rd_data  output  WIDTH  recorded sample at the read pointer
- rd_last  output  1  current rd_data is the final recorded sample
- count  output  ADDR_W+1  number of samples recorded, 0..DEPTH
- busy  output  1  high in CAPTURE or DUMP
- done  output  1  one-cycle pulse when the dump completes or capture ends empty

Behaviour:
- Reset (async assert, sync release):
  - State IDLE; wr_ptr, rd_ptr and count are 0.
  - rd_valid, rd_last, busy and done are 0; rd_data is 0.
  - Buffer contents are not reset.
- States: IDLE, CAPTURE, DUMP. All outputs are registered or decoded from registered state.
- IDLE:
  - arm=1 -> CAPTURE next cycle; wr_ptr and count clear to 0.
  - stop, sample_en and rd_ready are ignored.
- CAPTURE:
  - busy=1.
  - Each cycle with sample_en=1, write mem[wr_ptr]=sample_data; wr_ptr and count increment.
  - Full: when the write brings count to DEPTH, go to DUMP next cycle. Further sample_en in that transition cycle is not possible, and later samples are dropped.
  - stop=1 with sample_en=1 in the same cycle: the sample is written, then the block leaves CAPTURE.
  - stop=1 with count (after any write this cycle) > 0: go to DUMP.
  - stop=1 with count == 0: go to IDLE and pulse done the next cycle; rd_valid never asserts.
  - arm is ignored.
- DUMP:
  - busy=1 and rd_valid=1. rd_ptr starts at 0 on entry.
  - rd_data = mem[rd_ptr].
  - rd_last = (rd_ptr == count-1).
  - Transfer occurs on rd_valid && rd_ready; rd_ptr then increments.
  - rd_data and rd_last hold stable while rd_ready=0.
  - Transfer with rd_last=1: go to IDLE. done=1 for exactly one cycle, rd_valid drops the same cycle.
  - count stays valid in IDLE until the next arm.
  - arm, stop and sample_en are ignored.
- Latency:
  - Sample to buffer: 1 cycle.
  - First rd_valid: cycle after the capture ends.
  - Throughput: 1 sample/cycle with rd_ready held high.
- Mid-operation reset: immediate return to the reset values above; any partial capture is discarded.
- Pointer wrap: none. Capture stops at DEPTH and wr_ptr never wraps.

Optional Feature:
- Macro TRACE_DELTA_EN.
- Defined: change-compressed capture, matching VCD semantics.
  - In CAPTURE, a sample with sample_en=1 is written only if it is the first sample of the capture, or sample_data differs from the last written sample.
  - Unchanged samples do not advance count and do not count toward full.
  - stop handling is unchanged.
- Undefined: every sample_en cycle is recorded. No last-value register is synthesized.

Test Plan:
- Reset, then arm; sample_en high for 4 cycles with data 3'b000, 3'b011, 3'b101, 3'b110; stop on the 4th cycle.
  - Required: count=4.
  - rd_valid rises the next cycle.
  - With rd_ready=1, rd_data is 0,3,5,6 on consecutive cycles, rd_last=1 only on 6.
  - done pulses once; busy falls.
- Arm, 20 consecutive sample_en cycles with data i[2:0], i=0..19.
  - Required: count=16, samples 16..19 are dropped.
  - Dump yields 0..7,0..7; rd_last on the 16th beat.
- Dump with rd_ready toggling 1,0,0,1,...
  - Required: rd_data and rd_last stable while rd_ready=0.
  - No sample is skipped or duplicated.
- Arm, then stop with no sample_en.
  - Required: return to IDLE, done pulses, rd_valid stays 0, count=0.
- Assert rst mid-dump after 2 transfers.
  - Required: rd_valid=0, busy=0, count=0 immediately.
  - A new arm and capture works normally.
- With TRACE_DELTA_EN: data 1,1,1,2,2,4 on 6 sample_en cycles, then stop.
  - Required: count=3; dump yields 1,2,4.
  - Without the macro: count=6; dump yields 1,1,1,2,2,4.
